// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoding table for the sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}; 111 maps to zero, so neg is masked there.
  function automatic digit_t booth_recode(input logic [2:0] t);
    digit_t d;
    d.neg = t[2] & ~(t[1] & t[0]);
    d.one = t[1] ^ t[0];
    d.two = (t == 3'b011) | (t == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// Operand/product valid-ready bundle between a producer/consumer and the multiplier.
interface booth_r4_seq_mult_if #(
  parameter int unsigned W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth digit encoder: one triplet to {neg, one, two}.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  output digit_t     digit_o
);

  assign digit_o = booth_recode(triplet_i);

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, exact 2W-bit product,
// valid/ready on both sides, signed or unsigned operands.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic               clk,
  input logic               rst,
  booth_r4_seq_mult_if.slave bus
);

  localparam int unsigned ND = W / 2 + 1;
  localparam int unsigned WE = W + 2;
  localparam int unsigned AW = 2 * W + 2;
  localparam int unsigned CW = $clog2(ND);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WE-1:0]  a_q, a_d;
  logic [WE:0]    b_q, b_d;   // bit 0 is the implicit b[-1]
  logic [AW-1:0]  acc_q, acc_d;
  logic [2*W-1:0] p_q, p_d;

  logic [CW:0]    sh;
  logic [2:0]     triplet;
  digit_t         digit;
  logic [AW-1:0]  a_ext, mag, mag_sh, pp, acc_sum;

  assign sh      = {cnt_q, 1'b0};
  assign triplet = b_q[sh +: 3];

  booth_r4_enc u_enc (
    .triplet_i (triplet),
    .digit_o   (digit)
  );

  // Left-shifted multiplicand weights digit i by 4^i; negation uses the adder carry-in.
  always_comb begin
    a_ext   = {{(AW - WE){a_q[WE-1]}}, a_q};
    mag     = digit.two ? (a_ext << 1) : (digit.one ? a_ext : '0);
    mag_sh  = mag << sh;
    pp      = digit.neg ? ~mag_sh : mag_sh;
    acc_sum = acc_q + pp + AW'(digit.neg);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.signed_mode ? {{2{bus.a[W-1]}}, bus.a} : {2'b00, bus.a};
          b_d     = bus.signed_mode ? {{2{bus.b[W-1]}}, bus.b, 1'b0} : {2'b00, bus.b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ND - 1)) begin
          cnt_d   = '0;
          p_d     = acc_sum[2*W-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed vector table, multi-cycle corner sequences and a short random sweep at W=8.
module tb_booth_r4_seq_mult;

  localparam int unsigned W  = 8;
  localparam int unsigned ND = W / 2 + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  booth_r4_seq_mult_if #(.W(W)) bus ();

  booth_r4_seq_mult #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_txn(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name, input int gap,
                         input int rdy_dly);
    int n;
    repeat (gap) tick();
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.signed_mode = sm;
    bus.a           = a;
    bus.b           = b;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.signed_mode = ~sm;
    wait_valid(n);
    check({name, "_latency"}, 32'(n + 1), 32'(ND + 1));
    check({name, "_p"}, 32'(bus.p), 32'(exp));
    repeat (rdy_dly) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_post_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int          n;
    logic        seen;
    logic        sm;
    logic [7:0]  ra, rb;
    logic [31:0] ea, eb, prod;

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[4]  = '{1'b1, 8'h00, 8'hA5, 16'h0000};
    vecs[5]  = '{1'b0, 8'h5A, 8'h00, 16'h0000};
    vecs[6]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[8]  = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
    vecs[9]  = '{1'b1, 8'h03, 8'hFD, 16'hFFF7};
    vecs[10] = '{1'b0, 8'hA5, 8'h5A, 16'h3A02};
    vecs[11] = '{1'b1, 8'hA5, 8'h5A, 16'hE002};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_p", 32'(bus.p), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 0, 0);
    end

    // Back-pressure: output held for 10 cycles while in_valid is asserted throughout.
    bus.in_valid    = 1'b1;
    bus.signed_mode = 1'b0;
    bus.a           = 8'h12;
    bus.b           = 8'h34;
    tick();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    wait_valid(n);
    check("bp_latency", 32'(n + 1), 32'(ND + 1));
    check("bp_p", 32'(bus.p), 32'h03A8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_ready%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_hold_p%0d", i), 32'(bus.p), 32'h03A8);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_p_held", 32'(bus.p), 32'h03A8);

    // Reset in the third RUN cycle discards the transaction.
    bus.in_valid    = 1'b1;
    bus.signed_mode = 1'b1;
    bus.a           = 8'h7F;
    bus.b           = 8'h7F;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_in_ready", 32'(bus.in_ready), 32'd1);
    check("rstrun_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstrun_p", 32'(bus.p), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("rstrun_no_output", 32'(seen), 32'd0);
    run_txn(1'b1, 8'h03, 8'h05, 16'h000F, "rstrun_next", 0, 0);

    // Random pairs against a plain-multiply reference.
    for (int i = 0; i < 300; i++) begin
      sm   = 1'($urandom_range(0, 1));
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ea   = sm ? {{24{ra[7]}}, ra} : {24'd0, ra};
      eb   = sm ? {{24{rb[7]}}, rb} : {24'd0, rb};
      prod = ea * eb;
      run_txn(sm, ra, rb, prod[15:0], $sformatf("rnd%0d_sm%0d_%02h_%02h", i, sm, ra, rb),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
